mux_arb_reg: RTL
================

# mux_arb_reg

Parametrised, registered N-to-1 data selector with valid/ready handshakes, the pipeline-grade replacement for the fixed 4-input 16-bit selectors in the CPU datapath. It runs in one of two modes. In direct mode an explicit select picks the channel. In round-robin mode it arbitrates fairly among requesting channels. The chosen word and its source index are captured into a single output register stage. It sits wherever several producers share one consumer: writeback source merge, forwarding paths, memory-port sharing.

## Interface
Parameters:
- WIDTH, 16, data width per channel
- N, 4, channel count (N ≥ 2)
- SW, $clog2(N), select/index width (derived, not overridden)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, synchronous, active-high
- mode_i  in  1  0 = direct select, 1 = round-robin
- sel_i  in  SW  channel index used in direct mode
- in_valid_i  in  N  per-channel request
- in_data_i  in  N*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
- in_ready_o  out  N  per-channel accept (one-hot or zero)
- out_valid_o  out  1  output register holds a word
- out_data_o  out  WIDTH  registered data
- out_src_o  out  SW  index of the channel that supplied out_data_o
- out_ready_i  in  1  downstream accept

## Operation
- load = !out_valid_o || out_ready_i. The stage accepts at most one word per cycle, and only when load = 1.
- Direct mode:
  - Candidate is sel_i. Grant when in_valid_i[sel_i] = 1.
  - If sel_i ≥ N (non-power-of-two N), there is no grant.
- Round-robin mode:
  - Search channels ptr+1, ptr+2, … wrapping modulo N, ending at ptr.
  - The first channel with in_valid_i = 1 is granted.
- ptr holds the last round-robin grant index. It updates to the granted index only on a round-robin grant with load = 1. Direct-mode grants leave ptr unchanged.
- in_ready_o[g] = load && grant && (g = granted index). All other bits are 0. The transfer on channel g completes on that cycle edge.
- On a transfer:
  - out_data_o ← in_data_i[g]
  - out_src_o ← g
  - out_valid_o ← 1
- If load = 1 and no grant, out_valid_o ← 0. out_data_o and out_src_o hold their old values.
- If load = 0, all output registers hold. This applies even when requests are pending.
- mode_i and sel_i are sampled every cycle. A mode switch affects the grant in the same cycle it is presented, and ptr is preserved across mode switches.
- Reset values: out_valid_o = 0, out_data_o = 0, out_src_o = 0, ptr = N-1 (the first round-robin search starts at channel 0).
- in_ready_o is combinational from state and inputs. out_* are purely registered.

## Timing
- Latency: one cycle from the accepting edge (in_valid_i[g] && in_ready_o[g]) to out_valid_o = 1.
- Throughput: one word per cycle while out_ready_i = 1.
- Back-pressure: with out_valid_o = 1 and out_ready_i = 0, in_ready_o = 0 and out_* are stable.
- Simultaneous pop and push (out_valid_o = 1, out_ready_i = 1, grant present): the old word leaves and the new word is loaded on the same edge, with no bubble.
- If rst_i is asserted mid-transfer, reset wins. The word is dropped and in_ready_o = 0 during reset cycles.
- Round-robin fairness: a continuously requesting channel is granted within N transfers.

## Structure
- Shared package `mux_arb_pkg` holds:
  - MODE_SEL = 1'b0, MODE_RR = 1'b1
  - a helper function for channel-slice extraction
- Sub-module `rr_pick`:
  - purely combinational
  - inputs: req[N], ptr[SW]; outputs: any, idx[SW]
  - rotate-priority search, reused by other arbiters in the CPU
- Top level contains the load logic, mode mux, ptr register and output register.

## Test plan
- Reset, direct mode: rst_i held 2 cycles, then sel_i = 2, in_valid_i = 4'b0100, data2 = 16'hBEEF, out_ready_i = 1. Required:
  - in_ready_o = 4'b0100
  - next cycle out_valid_o = 1, out_data_o = 16'hBEEF, out_src_o = 2
  - all outputs are 0 during reset
- Direct mode, unselected request: sel_i = 1, in_valid_i = 4'b0100. Required: in_ready_o = 0 and out_valid_o drops to 0 the next cycle.
- Round-robin rotation: all four channels valid continuously, out_ready_i = 1. Required:
  - out_src_o sequence 0, 1, 2, 3, 0 on consecutive cycles
  - one in_ready_o bit per cycle
- Round-robin skip and wrap: ptr = 3, in_valid_i = 4'b1010. Required: grant 1, then 3, then 1.
- Back-pressure: a word is held with out_ready_i = 0 for 3 cycles while channel 0 requests. Required:
  - out_data_o stable and in_ready_o = 0 throughout
  - on release, the held word leaves and channel 0 loads on the same edge
- Mid-stream reset: rst_i pulsed while out_valid_o = 1. Required:
  - out_valid_o = 0 next cycle
  - ptr restarts, so the first round-robin grant is channel 0

Source files
------------

// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared mode encodings and channel-slice helper for the selector datapath
package mux_arb_pkg;
  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR = 1'b1;
  function automatic int chan_lo(input int k, input int w);
    return k * w;
  endfunction
endpackage

// File: rtl/mux_arb_reg_rr_pick.sv
// rr_pick: rotate-priority search starting just after ptr, wrapping modulo N
module rr_pick #(
  parameter int N = 4,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic          any,
  output logic [SW-1:0] idx
);
  always_comb begin
    any = 1'b0;
    idx = '0;
    // walk from farthest to nearest so the nearest requester wins
    for (int i = N; i >= 1; i--) begin
      if (req[SW'((int'(ptr) + i) % N)]) begin
        any = 1'b1;
        idx = SW'((int'(ptr) + i) % N);
      end
    end
  end
endmodule

// File: rtl/mux_arb_reg.sv
// mux_arb_reg: registered N-to-1 selector with direct or round-robin channel choice
module mux_arb_reg
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N = 4,
  localparam int SW = $clog2(N)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             mode_i,
  input  logic [SW-1:0]    sel_i,
  input  logic [N-1:0]     in_valid_i,
  input  logic [N*WIDTH-1:0] in_data_i,
  output logic [N-1:0]     in_ready_o,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic [SW-1:0]    out_src_o,
  input  logic             out_ready_i
);
  logic [SW-1:0] ptr, rr_idx, gidx;
  logic rr_any, sel_ok, grant, load;
  logic [2**SW-1:0] vpad;
  logic [WIDTH-1:0] gdata;
  rr_pick #(.N(N), .SW(SW)) u_pick (.req(in_valid_i), .ptr(ptr), .any(rr_any), .idx(rr_idx));
  // padding makes out-of-range selects read as no request for non-power-of-two N
  always_comb begin
    vpad = '0;
    vpad[N-1:0] = in_valid_i;
  end
  assign sel_ok = vpad[sel_i];
  assign load = !out_valid_o || out_ready_i;
  assign grant = mode_i == MODE_SEL ? sel_ok : rr_any;
  assign gidx = mode_i == MODE_SEL ? sel_i : rr_idx;
  assign in_ready_o = (load && grant && !rst_i) ? N'(1) << gidx : '0;
  always_comb begin
    gdata = '0;
    for (int k = 0; k < N; k++)
      if (gidx == SW'(k)) gdata = in_data_i[chan_lo(k, WIDTH) +: WIDTH];
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      out_data_o <= '0;
      out_src_o <= '0;
      ptr <= SW'(N - 1);
    end else if (load) begin
      out_valid_o <= grant;
      if (grant) begin
        out_data_o <= gdata;
        out_src_o <= gidx;
      end
      if (grant && mode_i == MODE_RR) ptr <= gidx;
    end
  end
endmodule
